pipe_hazard_ctrl: RTL and testbench

//  Hazard/stall controller for the 5-stage pipeline (F,D,E,M,W). Drives the enable/clear

---
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage (F,D,E,M,W) pipeline.
// Produces enables and bubble-clears for the PC and FD/DE/EM/MW registers.
// It handles data-memory wait states, multi-cycle FPU ops held in E,
// load-use hazards and taken-branch flushes.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  S_RUN      | normal flow; MEM > FPU > branch/load-use evaluated each cycle
//  S_FPU_WAIT | FPU op held in E; r_cnt counts remaining hold cycles
//  S_MEM_WAIT | M waiting on data memory; front of pipe frozen
//
// A wait state's release cycle still reports busy. In that cycle the RUN
// rules are re-evaluated, minus the rule that caused the wait.
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 6,
    parameter int FPU_LAT = 4,
    parameter int CNT_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [REG_AW-1:0] i_rs1_d,
    input  logic [REG_AW-1:0] i_rs2_d,
    input  logic              i_use_rs1_d,
    input  logic              i_use_rs2_d,
    input  logic [REG_AW-1:0] i_rd_e,
    input  logic              i_memread_e,
    input  logic              i_regwrite_e,
    input  logic              i_fpu_start_e,
    input  logic              i_branch_taken_e,
    input  logic              i_mem_req_m,
    input  logic              i_mem_ready,
    output logic              o_en_pc,
    output logic              o_en_fd,
    output logic              o_en_de,
    output logic              o_en_em,
    output logic              o_clr_fd,
    output logic              o_clr_de,
    output logic              o_clr_em,
    output logic              o_clr_mw,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_FPU_WAIT = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    // The entry cycle is the first stall cycle, and the release cycle is the last E cycle.
    // Hence FPU_LAT-2 further stall cycles are counted in FPU_WAIT.
    localparam bit               LP_FPU_HOLD = (FPU_LAT > 1);
    localparam logic [CNT_W-1:0] LP_FPU_LOAD = (FPU_LAT > 1) ? CNT_W'(FPU_LAT - 2) : '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load_use;
    logic             w_eval;
    logic             w_chk_mem;
    logic             w_chk_fpu;

    // Load in E feeding a register that D is about to read (x0 never hazards).
    assign w_load_use = i_memread_e & i_regwrite_e & (i_rd_e != '0) &
                        ((i_use_rs1_d & (i_rs1_d == i_rd_e)) |
                         (i_use_rs2_d & (i_rs2_d == i_rd_e)));

    // Next-state decode and combinational pipeline controls.
    always_comb begin
        o_en_pc     = 1'b1;
        o_en_fd     = 1'b1;
        o_en_de     = 1'b1;
        o_en_em     = 1'b1;
        o_clr_fd    = 1'b0;
        o_clr_de    = 1'b0;
        o_clr_em    = 1'b0;
        o_clr_mw    = 1'b0;
        o_busy      = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_eval      = 1'b0;
        w_chk_mem   = 1'b0;
        w_chk_fpu   = 1'b0;

        case (r_state)
            S_FPU_WAIT: begin
                o_busy = 1'b1;
                if (r_cnt != '0) begin
                    o_en_pc   = 1'b0;
                    o_en_fd   = 1'b0;
                    o_en_de   = 1'b0;
                    o_clr_em  = 1'b1;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_eval      = 1'b1;
                    w_chk_mem   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                o_busy = 1'b1;
                if (!i_mem_ready) begin
                    o_en_pc  = 1'b0;
                    o_en_fd  = 1'b0;
                    o_en_de  = 1'b0;
                    o_en_em  = 1'b0;
                    o_clr_mw = 1'b1;
                end else begin
                    w_eval      = 1'b1;
                    w_chk_fpu   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_eval      = 1'b1;
                w_chk_mem   = 1'b1;
                w_chk_fpu   = 1'b1;
                w_state_nxt = S_RUN;
            end
        endcase

        if (w_eval) begin
            if (w_chk_mem && i_mem_req_m && !i_mem_ready) begin
                o_en_pc     = 1'b0;
                o_en_fd     = 1'b0;
                o_en_de     = 1'b0;
                o_en_em     = 1'b0;
                o_clr_mw    = 1'b1;
                w_state_nxt = S_MEM_WAIT;
            end else if (w_chk_fpu && i_fpu_start_e && LP_FPU_HOLD) begin
                o_en_pc     = 1'b0;
                o_en_fd     = 1'b0;
                o_en_de     = 1'b0;
                o_clr_em    = 1'b1;
                w_cnt_nxt   = LP_FPU_LOAD;
                w_state_nxt = S_FPU_WAIT;
            end else if (i_branch_taken_e) begin
                // D is flushed by the branch, so a load-use stall on it is moot.
                o_clr_fd = 1'b1;
                o_clr_de = 1'b1;
            end else if (w_load_use) begin
                o_en_pc  = 1'b0;
                o_en_fd  = 1'b0;
                o_clr_de = 1'b1;
            end
        end

        if (i_reset) begin
            o_en_pc  = 1'b0;
            o_en_fd  = 1'b0;
            o_en_de  = 1'b0;
            o_en_em  = 1'b0;
            o_clr_fd = 1'b1;
            o_clr_de = 1'b1;
            o_clr_em = 1'b1;
            o_clr_mw = 1'b1;
            o_busy   = 1'b0;
        end
    end

    // State and FPU hold counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. It runs one instance with FPU_LAT=4 and one with FPU_LAT=1.
// Observation vector: {en_pc,en_fd,en_de,en_em,clr_fd,clr_de,clr_em,clr_mw,busy}.
// Stimulus vector: {reset, mem_req, mem_ready, fpu, branch, memread, regwrite,
//                   use_rs1, use_rs2, rd_e[5:0]}.
// rs1_d defaults to 5 and rs2_d defaults to 7.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] rs1_d, rs2_d, rd_e;
    logic       use_rs1_d, use_rs2_d, memread_e, regwrite_e, fpu_start_e;
    logic       branch_taken_e, mem_req_m, mem_ready;

    logic a_en_pc, a_en_fd, a_en_de, a_en_em, a_clr_fd, a_clr_de, a_clr_em, a_clr_mw, a_busy;
    logic b_en_pc, b_en_fd, b_en_de, b_en_em, b_clr_fd, b_clr_de, b_clr_em, b_clr_mw, b_busy;

    logic [8:0] obs_a, obs_b;
    assign obs_a = {a_en_pc, a_en_fd, a_en_de, a_en_em, a_clr_fd, a_clr_de, a_clr_em, a_clr_mw, a_busy};
    assign obs_b = {b_en_pc, b_en_fd, b_en_de, b_en_em, b_clr_fd, b_clr_de, b_clr_em, b_clr_mw, b_busy};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(6), .FPU_LAT(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_reset(reset), .i_rs1_d(rs1_d), .i_rs2_d(rs2_d),
        .i_use_rs1_d(use_rs1_d), .i_use_rs2_d(use_rs2_d), .i_rd_e(rd_e),
        .i_memread_e(memread_e), .i_regwrite_e(regwrite_e), .i_fpu_start_e(fpu_start_e),
        .i_branch_taken_e(branch_taken_e), .i_mem_req_m(mem_req_m), .i_mem_ready(mem_ready),
        .o_en_pc(a_en_pc), .o_en_fd(a_en_fd), .o_en_de(a_en_de), .o_en_em(a_en_em),
        .o_clr_fd(a_clr_fd), .o_clr_de(a_clr_de), .o_clr_em(a_clr_em), .o_clr_mw(a_clr_mw),
        .o_busy(a_busy)
    );

    pipe_hazard_ctrl #(.REG_AW(6), .FPU_LAT(1), .CNT_W(8)) dut_lat1 (
        .i_clk(clk), .i_reset(reset), .i_rs1_d(rs1_d), .i_rs2_d(rs2_d),
        .i_use_rs1_d(use_rs1_d), .i_use_rs2_d(use_rs2_d), .i_rd_e(rd_e),
        .i_memread_e(memread_e), .i_regwrite_e(regwrite_e), .i_fpu_start_e(fpu_start_e),
        .i_branch_taken_e(branch_taken_e), .i_mem_req_m(mem_req_m), .i_mem_ready(mem_ready),
        .o_en_pc(b_en_pc), .o_en_fd(b_en_fd), .o_en_de(b_en_de), .o_en_em(b_en_em),
        .o_clr_fd(b_clr_fd), .o_clr_de(b_clr_de), .o_clr_em(b_clr_em), .o_clr_mw(b_clr_mw),
        .o_busy(b_busy)
    );

    localparam logic [8:0] IDLE = 9'b1111_0000_0;
    localparam logic [8:0] RST  = 9'b0000_1111_0;
    localparam logic [8:0] LU   = 9'b0011_0100_0;
    localparam logic [8:0] BR   = 9'b1111_1100_0;

    // Drive one stimulus vector just after the falling edge; the caller samples 1 time unit later.
    task automatic apply(input logic [14:0] s);
        @(negedge clk);
        reset          = s[14];
        mem_req_m      = s[13];
        mem_ready      = s[12];
        fpu_start_e    = s[11];
        branch_taken_e = s[10];
        memread_e      = s[9];
        regwrite_e     = s[8];
        use_rs1_d      = s[7];
        use_rs2_d      = s[6];
        rd_e           = s[5:0];
    endtask

    task automatic test_reset();
        logic [14:0] stim [4] = '{15'b1_00_0_0_00_00_000000, 15'b1_10_1_0_11_10_000101,
                                  15'b0_00_0_0_00_00_000000, 15'b0_00_0_0_00_00_000000};
        logic [8:0]  exp  [4] = '{RST, RST, IDLE, IDLE};
        for (int i = 0; i < 4; i++) begin
            apply(stim[i]);
            #1;
            n_chk++;
            if (obs_a !== exp[i]) begin
                n_fail++;
                $display("FAIL reset step %0d: got %b want %b", i, obs_a, exp[i]);
            end
        end
    endtask

    task automatic test_load_use();
        logic [14:0] stim [6] = '{15'b0_00_0_0_11_10_000101, 15'b0_00_0_0_00_10_000000,
                                  15'b0_00_0_0_11_01_000111, 15'b0_00_0_0_11_00_000101,
                                  15'b0_00_0_0_10_10_000101, 15'b0_00_0_0_11_11_000110};
        logic [8:0]  exp  [6] = '{LU, IDLE, LU, IDLE, IDLE, IDLE};
        for (int i = 0; i < 6; i++) begin
            apply(stim[i]);
            #1;
            n_chk++;
            if (obs_a !== exp[i]) begin
                n_fail++;
                $display("FAIL load_use step %0d: got %b want %b", i, obs_a, exp[i]);
            end
        end
        // A load to x0 is never a hazard, even when D reads x0.
        rs1_d = 6'd0;
        rs2_d = 6'd0;
        apply(15'b0_00_0_0_11_11_000000);
        #1;
        n_chk++;
        if (obs_a !== IDLE) begin
            n_fail++;
            $display("FAIL load_use_x0: got %b want %b", obs_a, IDLE);
        end
        rs1_d = 6'd5;
        rs2_d = 6'd7;
    endtask

    task automatic test_fpu();
        logic [14:0] stim [9] = '{15'b0_00_1_0_00_00_000000, 15'b0_00_1_0_00_00_000000,
                                  15'b0_00_1_0_00_00_000000, 15'b0_00_1_0_00_00_000000,
                                  15'b0_00_0_0_00_00_000000,
                                  15'b0_00_1_0_00_00_000000, 15'b0_00_1_0_00_00_000000,
                                  15'b0_00_1_0_00_00_000000, 15'b0_00_1_0_11_10_000101};
        logic [8:0]  exp  [9] = '{9'b0001_0010_0, 9'b0001_0010_1, 9'b0001_0010_1,
                                  9'b1111_0000_1, IDLE,
                                  9'b0001_0010_0, 9'b0001_0010_1, 9'b0001_0010_1,
                                  9'b0011_0100_1};
        logic [8:0]  exp1 [9] = '{IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, LU};
        for (int i = 0; i < 9; i++) begin
            apply(stim[i]);
            #1;
            n_chk++;
            if (obs_a !== exp[i]) begin
                n_fail++;
                $display("FAIL fpu_lat4 step %0d: got %b want %b", i, obs_a, exp[i]);
            end
            n_chk++;
            if (obs_b !== exp1[i]) begin
                n_fail++;
                $display("FAIL fpu_lat1 step %0d: got %b want %b", i, obs_b, exp1[i]);
            end
        end
        apply(15'b0_00_0_0_00_00_000000);
    endtask

    task automatic test_mem();
        logic [14:0] stim [13] = '{15'b0_11_0_0_00_00_000000,
                                   15'b0_10_0_0_00_00_000000, 15'b0_10_0_0_00_00_000000,
                                   15'b0_10_0_0_00_00_000000, 15'b0_11_0_0_00_00_000000,
                                   15'b0_00_0_0_00_00_000000,
                                   15'b0_10_1_0_00_00_000000, 15'b0_10_1_0_00_00_000000,
                                   15'b0_11_1_0_00_00_000000, 15'b0_00_1_0_00_00_000000,
                                   15'b0_00_1_0_00_00_000000, 15'b0_00_1_0_00_00_000000,
                                   15'b0_00_0_0_00_00_000000};
        logic [8:0]  exp  [13] = '{IDLE,
                                   9'b0000_0001_0, 9'b0000_0001_1, 9'b0000_0001_1,
                                   9'b1111_0000_1, IDLE,
                                   9'b0000_0001_0, 9'b0000_0001_1,
                                   9'b0001_0010_1, 9'b0001_0010_1, 9'b0001_0010_1,
                                   9'b1111_0000_1, IDLE};
        for (int i = 0; i < 13; i++) begin
            apply(stim[i]);
            #1;
            n_chk++;
            if (obs_a !== exp[i]) begin
                n_fail++;
                $display("FAIL mem step %0d: got %b want %b", i, obs_a, exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [14:0] stim [6] = '{15'b0_00_0_1_11_10_000101, 15'b0_00_0_1_00_00_000000,
                                  15'b0_10_0_1_00_00_000000, 15'b0_10_0_1_00_00_000000,
                                  15'b0_11_0_1_00_00_000000, 15'b0_00_0_0_00_00_000000};
        logic [8:0]  exp  [6] = '{BR, BR, 9'b0000_0001_0, 9'b0000_0001_1,
                                  9'b1111_1100_1, IDLE};
        for (int i = 0; i < 6; i++) begin
            apply(stim[i]);
            #1;
            n_chk++;
            if (obs_a !== exp[i]) begin
                n_fail++;
                $display("FAIL branch step %0d: got %b want %b", i, obs_a, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [14:0] stim [5] = '{15'b0_00_1_0_00_00_000000, 15'b0_00_1_0_00_00_000000,
                                  15'b1_00_1_0_00_00_000000, 15'b0_00_0_0_00_00_000000,
                                  15'b0_00_0_0_00_00_000000};
        logic [8:0]  exp  [5] = '{9'b0001_0010_0, 9'b0001_0010_1, RST, IDLE, IDLE};
        for (int i = 0; i < 5; i++) begin
            apply(stim[i]);
            #1;
            n_chk++;
            if (obs_a !== exp[i]) begin
                n_fail++;
                $display("FAIL reset_mid_wait step %0d: got %b want %b", i, obs_a, exp[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        rs1_d = 6'd5;
        rs2_d = 6'd7;
        rd_e = '0;
        use_rs1_d = 1'b0;
        use_rs2_d = 1'b0;
        memread_e = 1'b0;
        regwrite_e = 1'b0;
        fpu_start_e = 1'b0;
        branch_taken_e = 1'b0;
        mem_req_m = 1'b0;
        mem_ready = 1'b0;

        test_reset();
        test_load_use();
        test_fpu();
        test_mem();
        test_branch();
        test_reset_mid_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
